// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues tagged ALU commands, drives the ALU hold-until-done handshake
// and returns tagged results, with NOP bypass, done-timeout abort and a 2-cycle start-low gap.
module alu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [2:0]               i_cmd_op,
  input  logic [7:0]               i_cmd_a,
  input  logic [7:0]               i_cmd_b,
  input  logic [TAG_W-1:0]         i_cmd_tag,
  output logic [7:0]               o_alu_a,
  output logic [7:0]               o_alu_b,
  output logic [2:0]               o_alu_op,
  output logic                     o_alu_start,
  input  logic                     i_alu_done,
  input  logic [15:0]              i_alu_result,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [15:0]              o_rsp_result,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [2:0]               o_rsp_op,
  output logic                     o_rsp_err,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 19 + TAG_W;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP1, S_GAP2} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [7:0] r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [EW-1:0] w_head;
  logic w_push, w_pop, w_nop, w_slot_free, w_done, w_tmo;
  assign o_level     = r_wp - r_rp;
  assign o_cmd_ready = !i_reset && (o_level != (AW+1)'(DEPTH));
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_head      = r_mem[r_rp[AW-1:0]];
  assign w_nop       = w_head[EW-1 -: 3] == 3'b000;
  // the response slot may be refilled in the same cycle it is handed off
  assign w_slot_free = !o_rsp_valid || i_rsp_ready;
  always_comb begin
    w_pop  = (r_state == S_IDLE || r_state == S_GAP2) && o_level != '0 && w_slot_free;
    w_done = r_state == S_ISSUE && i_alu_done;
    w_tmo  = r_state == S_ISSUE && !i_alu_done && r_cnt == 8'(TIMEOUT);
    w_next = (w_pop && !w_nop) ? S_ISSUE :
             (w_done || w_tmo) ? S_GAP1  :
             r_state == S_GAP1 ? S_GAP2  :
             r_state == S_GAP2 ? S_IDLE  : r_state;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {i_cmd_op, i_cmd_a, i_cmd_b, i_cmd_tag};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_tag        <= '0;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_op     <= '0;
      o_alu_start  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_tag    <= '0;
      o_rsp_op     <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      r_cnt       <= w_pop ? 8'd1 : r_cnt + 8'd1;
      o_alu_start <= w_next == S_ISSUE;
      if (w_pop && !w_nop) begin
        o_alu_op <= w_head[EW-1 -: 3];
        o_alu_a  <= w_head[TAG_W+15 -: 8];
        o_alu_b  <= w_head[TAG_W+7 -: 8];
        r_tag    <= w_head[TAG_W-1:0];
      end
      if (o_rsp_valid && i_rsp_ready) o_rsp_valid <= 1'b0;
      if (w_pop && w_nop) begin
        o_rsp_valid  <= 1'b1;
        o_rsp_result <= '0;
        o_rsp_err    <= 1'b0;
        o_rsp_tag    <= w_head[TAG_W-1:0];
        o_rsp_op     <= 3'b000;
      end
      if (w_done || w_tmo) begin
        o_rsp_valid  <= 1'b1;
        o_rsp_result <= w_done ? i_alu_result : 16'd0;
        o_rsp_err    <= w_tmo;
        o_rsp_tag    <= r_tag;
        o_rsp_op     <= o_alu_op;
      end
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command sequencer directly upstream of the tiny ALU. Accepts operand/opcode commands over a valid/ready interface into a small FIFO, drives the ALU's `A`/`B`/`op`/`start` under the ALU's hold-until-done protocol, and returns each result with its tag on a valid/ready response port. Adds NOP handling, a done-timeout guard and the mandatory start-low gap between commands.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TAG_W`, 4: tag width.
- `TIMEOUT`, 15: maximum ISSUE cycles without `alu_done` before abort; range 6..255.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  `!full && !reset`.
- `cmd_op`  in  3  000 NOP, 001 ADD, 010 AND, 011 XOR, 1xx MUL.
- `cmd_a`, `cmd_b`  in  8  operands.
- `cmd_tag`  in  TAG_W  echoed on response.
- `alu_a`, `alu_b`  out  8  to ALU `A`/`B`; registered.
- `alu_op`  out  3  to ALU `op`; registered.
- `alu_start`  out  1  to ALU `start`; registered.
- `alu_done`  in  1  from ALU `done`.
- `alu_result`  in  16  from ALU `result`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  16  result; 0 for NOP or timeout.
- `rsp_tag`  out  TAG_W  tag of the command.
- `rsp_op`  out  3  opcode of the command.
- `rsp_err`  out  1  1 = timeout abort.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`. No fall-through: an entry is poppable starting the cycle after its push. Push and pop in the same cycle are both honoured.
- Response slot: single register. Freed on `rsp_valid && rsp_ready`. It counts as free in the same cycle it is being freed.
- State IDLE (`alu_start`=0):
  - Pops when the FIFO is non-empty and the response slot is free.
  - NOP: loads the response immediately (result 0, err 0) and stays in IDLE. No ALU access.
  - Otherwise: loads `alu_a`/`alu_b`/`alu_op` and sets `alu_start`=1, then goes to ISSUE.
- State ISSUE (`alu_start`=1, operands stable):
  - A cycle counter starts at 1.
  - On `alu_done`=1: captures `alu_result` into the response slot (err 0), clears `alu_start`, then goes to GAP.
  - If the counter reaches TIMEOUT without done: clears `alu_start`, loads response with result 0 and err 1, then goes to GAP.
- State GAP (`alu_start`=0): exactly 2 cycles. `alu_done` is ignored, because the ALU's done lingers after start falls. In the second GAP cycle the FSM applies IDLE's pop rule; if nothing is popped it goes to IDLE.
- The response slot is always free at capture: a pop requires a free slot, and the slot is not refilled before capture.
- `alu_op` holds its last value in IDLE/GAP. `alu_a`/`alu_b` change only on pop.

## Timing
- Reset values (asynchronous): state IDLE, FIFO empty, `level`=0, `cmd_ready`=0, `alu_start`=0, `alu_a`/`alu_b`/`alu_op`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_tag`=0, `rsp_op`=0, `rsp_err`=0.
- Reset mid-operation: `alu_start` drops immediately, and the in-flight command and all queued commands are discarded.
- Push at edge E into an empty idle block:
  - Pop, and `alu_start` rises, at edge E+1.
  - ADD/AND/XOR: done seen in cycle E+2..E+3; `rsp_valid` rises at edge E+3.
  - MUL: `rsp_valid` rises at edge E+6.
  - NOP: `rsp_valid` rises at edge E+1.
- Back-to-back single-cycle ops: `alu_start` high 2 cycles, low 2 cycles; one command per 4 cycles when `rsp_ready`=1. MUL: one per 7 cycles.
- `rsp_valid` stays high with all rsp fields stable until accepted. While it is held, no pop occurs and the FIFO can fill; `cmd_ready`=0 when full.
- `level` updates on the edge of push/pop.

## Test plan
- Reset, then push ADD a=200 b=100 tag=3 with `rsp_ready`=1 → `alu_start` 2 cycles; response result=300, tag=3, op=001, err=0, 3 cycles after push.
- Push MUL 255×255 → result=65025 at push+6. Then AND 0xF0&0x3C → 0x0030. Then XOR 0xFF^0x0F → 0x00F0. Exactly 2 `alu_start`-low cycles between commands.
- Push NOP tag=7 → response result=0, err=0, 1 cycle after push; `alu_start` never rises.
- Hold `rsp_ready`=0, push 5 ADDs with DEPTH=4 → first response held; FIFO fills, `level`=4, `cmd_ready`=0. Release → all 5 responses emerge in tag order, values correct.
- Tie `alu_done`=0, push ADD → `alu_start` high exactly 15 cycles; response err=1, result=0. Next command then proceeds normally.
- Assert `reset` during a MUL ISSUE → `alu_start`, `rsp_valid` and `level` go to 0 without waiting for a clock edge. After release, a new ADD 1+1 returns 2.
